// File: rtl/fetcher_if.sv
// fetcher_if: bundles the fetch stage's memory-request and decode-issue
// signals.
//   master : fetch stage side
//            drives out_mem_req/out_mem_addr and out_decode_*;
//            receives in_mem_ready/in_mem_instr and in_issue_stall.
//   slave  : memory controller / decode side (directions mirrored).
interface fetcher_if;
    logic        out_mem_req;
    logic [31:0] out_mem_addr;
    logic        in_mem_ready;
    logic [31:0] in_mem_instr;
    logic        out_decode_valid;
    logic [31:0] out_decode_instr;
    logic [31:0] out_decode_pc;
    logic        in_issue_stall;

    modport master (
        output out_mem_req, out_mem_addr,
               out_decode_valid, out_decode_instr, out_decode_pc,
        input  in_mem_ready, in_mem_instr, in_issue_stall
    );

    modport slave (
        input  out_mem_req, out_mem_addr,
               out_decode_valid, out_decode_instr, out_decode_pc,
        output in_mem_ready, in_mem_instr, in_issue_stall
    );
endinterface

// File: rtl/fetcher.sv
// fetcher: instruction fetch stage feeding decode.
// Keeps the fetch PC and issues one outstanding 32-bit fetch at a time.
// Returned words are queued together with their PCs in an IQ_DEPTH-entry
// queue. The queue head is presented to decode.
// JAL targets are followed at fetch time. A ROB flush redirects the PC and
// empties the queue.
//
// Ports:
//   clk              : clock, rising edge
//   rst              : asynchronous active-low reset
//   rdy              : global ready; low freezes all state
//   in_rob_flush     : one-cycle redirect pulse
//   in_rob_target_pc : redirect target, valid with in_rob_flush
//   bus              : fetcher_if.master
//                      memory request/response signals and decode issue
module fetcher #(
    parameter int          IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_rob_flush,
    input  logic [31:0] in_rob_target_pc,
    fetcher_if.master   bus
);
    localparam int             PW      = $clog2(IQ_DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(IQ_DEPTH);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [PW-1:0]  PTR_ONE = PW'(1);

    // WAIT keeps the in-flight response.
    // DROP discards it, because a flush arrived while it was outstanding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic          req_r, req_s;
    logic [31:0]   addr_r, addr_s;
    logic [31:0]   pc_r, pc_s;
    logic [PW-1:0] head_r, tail_r;
    logic [CW-1:0] count_r;
    logic [31:0]   iq_pc_r    [IQ_DEPTH];
    logic [31:0]   iq_instr_r [IQ_DEPTH];
    logic          push_s, pop_s, clear_s, valid_s;

    // Static next-PC prediction.
    // JAL is followed to its target; everything else falls through by 4.
    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] instr);
        logic [31:0] off;
        if (instr[6:0] == 7'b1101111) begin
            off = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        end else begin
            off = 32'd4;
        end
        return pc + off;
    endfunction

    assign valid_s              = (count_r != {CW{1'b0}});
    // A flush takes priority over a pop, so the head is not consumed that cycle.
    assign pop_s                = valid_s && !bus.in_issue_stall && !in_rob_flush;
    assign bus.out_mem_req      = req_r;
    assign bus.out_mem_addr     = addr_r;
    assign bus.out_decode_valid = valid_s;
    assign bus.out_decode_instr = valid_s ? iq_instr_r[head_r] : 32'h0;
    assign bus.out_decode_pc    = valid_s ? iq_pc_r[head_r]    : 32'h0;

    // Next-state, request and fetch-PC logic; a flush overrides normal sequencing.
    always_comb begin
        state_s = state_r;
        req_s   = req_r;
        addr_s  = addr_r;
        pc_s    = pc_r;
        push_s  = 1'b0;
        clear_s = 1'b0;
        if (in_rob_flush) begin
            clear_s = 1'b1;
            pc_s    = in_rob_target_pc;
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                    req_s   = 1'b0;
                end
                WAIT, DROP: begin
                    if (bus.in_mem_ready) begin
                        state_s = IDLE;
                        req_s   = 1'b0;
                    end else begin
                        state_s = DROP;
                    end
                end
                default: begin
                    state_s = IDLE;
                    req_s   = 1'b0;
                end
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    if (count_r < DEPTH_C) begin
                        state_s = WAIT;
                        req_s   = 1'b1;
                        addr_s  = pc_r;
                    end else begin
                        state_s = IDLE;
                        req_s   = 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.in_mem_ready) begin
                        push_s  = 1'b1;
                        req_s   = 1'b0;
                        state_s = IDLE;
                        pc_s    = next_pc(pc_r, bus.in_mem_instr);
                    end else begin
                        state_s = WAIT;
                    end
                end
                DROP: begin
                    if (bus.in_mem_ready) begin
                        req_s   = 1'b0;
                        state_s = IDLE;
                    end else begin
                        state_s = DROP;
                    end
                end
                default: begin
                    state_s = IDLE;
                    req_s   = 1'b0;
                end
            endcase
        end
    end

    // FSM, request outputs and fetch PC registers; frozen while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
            addr_r  <= 32'h0;
            pc_r    <= RESET_PC;
        end else if (rdy) begin
            state_r <= state_s;
            req_r   <= req_s;
            addr_r  <= addr_s;
            pc_r    <= pc_s;
        end
    end

    // Instruction queue storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < IQ_DEPTH; i++) begin
                iq_pc_r[i]    <= 32'h0;
                iq_instr_r[i] <= 32'h0;
            end
        end else if (rdy) begin
            if (clear_s) begin
                head_r  <= {PW{1'b0}};
                tail_r  <= {PW{1'b0}};
                count_r <= {CW{1'b0}};
            end else begin
                if (push_s) begin
                    iq_pc_r[tail_r]    <= pc_r;
                    iq_instr_r[tail_r] <= bus.in_mem_instr;
                    tail_r             <= tail_r + PTR_ONE;
                end
                if (pop_s) begin
                    head_r <= head_r + PTR_ONE;
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetcher.sv
// tb_fetcher: directed scoreboard bench for fetcher.
// The memory model and main sequence push the expected {pc, instr} stream.
// A separate monitor pops and compares on every decode acceptance.
module tb_fetcher;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        in_rob_flush = 1'b0;
    logic [31:0] in_rob_target_pc = 32'h0;

    fetcher_if bus();

    fetcher #(.IQ_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .in_rob_flush     (in_rob_flush),
        .in_rob_target_pc (in_rob_target_pc),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          pop_cnt = 0;
    int          wait_cnt = 0;
    int          lat = 0;
    int          budget;
    int          pops_before;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] cur_addr = 32'h0;
    logic [31:0] last_pop_pc = 32'hFFFF_FFFF;
    logic [31:0] snap_addr, snap_pc;
    logic        snap_req, snap_valid;
    bit          outstanding = 1'b0;
    bit          keep = 1'b0;
    bit          auto_mem = 1'b0;
    bit          prev_ready = 1'b0;
    bit          chk_timing = 1'b0;
    bit          saw_jal = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory contents: a JAL +16 sits at 0x10, other words are non-JAL.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h10) return 32'h0100_006F;
        return {a[24:0], 7'h13};
    endfunction

    // Hand-computed successor PC for the memory image above.
    function automatic logic [31:0] model_next(input logic [31:0] a);
        if (a == 32'h10) return 32'h20;
        return a + 32'd4;
    endfunction

    // Drive one cycle of inputs from the current outputs, then advance past the edge.
    task automatic tick(input bit fl, input logic [31:0] tgt);
        in_rob_flush     = fl;
        in_rob_target_pc = tgt;
        if (chk_timing) check("issue_timing", 32'(bus.out_decode_valid), 32'(prev_ready));
        bus.in_mem_ready = 1'b0;
        bus.in_mem_instr = 32'h0;
        if (auto_mem && rdy) begin
            if (outstanding) begin
                check("req_held", 32'(bus.out_mem_req), 32'd1);
                check("addr_stable", bus.out_mem_addr, cur_addr);
            end else if (bus.out_mem_req) begin
                check("req_addr", bus.out_mem_addr, exp_pc);
                outstanding = 1'b1;
                keep        = 1'b1;
                wait_cnt    = 0;
                cur_addr    = bus.out_mem_addr;
            end
        end
        if (fl) begin
            exp_pc = tgt;
            keep   = 1'b0;
            sb.delete();
        end
        if (auto_mem && rdy && outstanding) begin
            if (wait_cnt >= lat) begin
                bus.in_mem_ready = 1'b1;
                bus.in_mem_instr = word_at(cur_addr);
                if (keep) begin
                    sb.push_back('{cur_addr, word_at(cur_addr)});
                    exp_pc = model_next(cur_addr);
                end
                outstanding = 1'b0;
            end else begin
                wait_cnt++;
            end
        end
        prev_ready = bus.in_mem_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_pops(input int n);
        int b;
        b = 300;
        while (pop_cnt < n && b > 0) begin
            tick(1'b0, 32'h0);
            b--;
        end
        check("pop_progress", 32'(pop_cnt >= n), 32'd1);
    endtask

    // Scoreboard monitor: compare the decode head whenever decode accepts it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && rdy) begin
                if (bus.out_decode_valid && !bus.in_issue_stall && !in_rob_flush) begin
                    if (sb.size() == 0) begin
                        check("dec_unexpected_pc", bus.out_decode_pc, 32'hFFFF_FFFF);
                    end else begin
                        ent_t e;
                        e = sb.pop_front();
                        check("dec_pc", bus.out_decode_pc, e.pc);
                        check("dec_instr", bus.out_decode_instr, e.instr);
                    end
                    if (last_pop_pc == 32'h10 && bus.out_decode_pc == 32'h20) saw_jal = 1'b1;
                    last_pop_pc = bus.out_decode_pc;
                    pop_cnt++;
                end else if (!bus.out_decode_valid) begin
                    check("idle_instr_zero", bus.out_decode_instr, 32'h0);
                    check("idle_pc_zero", bus.out_decode_pc, 32'h0);
                end
            end
        end
    end

    // Main directed sequence.
    initial begin
        bus.in_mem_ready   = 1'b0;
        bus.in_mem_instr   = 32'h0;
        bus.in_issue_stall = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(bus.out_mem_req), 32'd0);
        check("rst_addr", bus.out_mem_addr, 32'h0);
        check("rst_valid", 32'(bus.out_decode_valid), 32'd0);
        check("rst_instr", bus.out_decode_instr, 32'h0);
        check("rst_pc", bus.out_decode_pc, 32'h0);

        // Sequential fetch with 1-cycle memory and no stall.
        rst = 1'b1;
        auto_mem = 1'b1;
        lat = 0;
        chk_timing = 1'b1;
        run_until_pops(3);
        chk_timing = 1'b0;

        // Fill the queue under stall, then drain on consecutive cycles.
        bus.in_issue_stall = 1'b1;
        repeat (20) tick(1'b0, 32'h0);
        check("full_no_req", 32'(bus.out_mem_req), 32'd0);
        check("full_count", 32'(sb.size()), 32'd4);
        check("full_valid", 32'(bus.out_decode_valid), 32'd1);
        bus.in_issue_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(bus.out_decode_valid), 32'd1);
            tick(1'b0, 32'h0);
        end
        run_until_pops(pop_cnt + 4);
        check("jal_followed", 32'(saw_jal), 32'd1);

        // Flush to 0x100 while a request is outstanding with a slow memory.
        lat = 3;
        bus.in_issue_stall = 1'b1;
        budget = 200;
        while (!(outstanding && wait_cnt == 1 && bus.out_decode_valid) && budget > 0) begin
            tick(1'b0, 32'h0);
            budget--;
        end
        check("flush_window_found", 32'(budget > 0), 32'd1);
        tick(1'b1, 32'h100);
        check("flush_valid", 32'(bus.out_decode_valid), 32'd0);
        check("flush_pc", bus.out_decode_pc, 32'h0);
        check("flush_drop_req", 32'(bus.out_mem_req), 32'd1);
        bus.in_issue_stall = 1'b0;
        budget = 20;
        while (outstanding && budget > 0) begin
            tick(1'b0, 32'h0);
            budget--;
        end
        lat = 0;
        run_until_pops(pop_cnt + 2);

        // Flush, memory response and a would-be pop all in one cycle.
        lat = 2;
        bus.in_issue_stall = 1'b1;
        budget = 200;
        while (!(outstanding && wait_cnt >= lat && bus.out_decode_valid) && budget > 0) begin
            tick(1'b0, 32'h0);
            budget--;
        end
        check("sim_window_found", 32'(budget > 0), 32'd1);
        bus.in_issue_stall = 1'b0;
        pops_before = pop_cnt;
        tick(1'b1, 32'h200);
        check("sim_no_pop", 32'(pop_cnt), 32'(pops_before));
        check("sim_valid", 32'(bus.out_decode_valid), 32'd0);
        check("sim_idle_req", 32'(bus.out_mem_req), 32'd0);
        lat = 0;
        run_until_pops(pop_cnt + 2);

        // Hold rdy low for 5 cycles while a request is outstanding.
        lat = 4;
        bus.in_issue_stall = 1'b1;
        budget = 200;
        while (!(outstanding && bus.out_decode_valid) && budget > 0) begin
            tick(1'b0, 32'h0);
            budget--;
        end
        check("rdy_window_found", 32'(budget > 0), 32'd1);
        snap_req   = bus.out_mem_req;
        snap_addr  = bus.out_mem_addr;
        snap_valid = bus.out_decode_valid;
        snap_pc    = bus.out_decode_pc;
        rdy = 1'b0;
        repeat (5) begin
            tick(1'b0, 32'h0);
            check("rdy_req", 32'(bus.out_mem_req), 32'(snap_req));
            check("rdy_addr", bus.out_mem_addr, snap_addr);
            check("rdy_valid", 32'(bus.out_decode_valid), 32'(snap_valid));
            check("rdy_pc", bus.out_decode_pc, snap_pc);
        end
        rdy = 1'b1;

        // Reset mid-request, then a stale response after reset release.
        budget = 200;
        while (!(outstanding && bus.out_decode_valid) && budget > 0) begin
            tick(1'b0, 32'h0);
            budget--;
        end
        check("rst_window_found", 32'(budget > 0), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_req", 32'(bus.out_mem_req), 32'd0);
        check("midrst_addr", bus.out_mem_addr, 32'h0);
        check("midrst_valid", 32'(bus.out_decode_valid), 32'd0);
        check("midrst_instr", bus.out_decode_instr, 32'h0);
        check("midrst_pc", bus.out_decode_pc, 32'h0);
        outstanding = 1'b0;
        sb.delete();
        exp_pc = 32'h0;
        auto_mem = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_mem_ready = 1'b1;
        bus.in_mem_instr = 32'hDEAD_0013;
        @(posedge clk);
        #1;
        bus.in_mem_ready = 1'b0;
        bus.in_mem_instr = 32'h0;
        check("late_ready_valid", 32'(bus.out_decode_valid), 32'd0);
        check("post_rst_req", 32'(bus.out_mem_req), 32'd1);
        check("post_rst_addr", bus.out_mem_addr, 32'h0);
        auto_mem = 1'b1;
        bus.in_issue_stall = 1'b0;
        lat = 0;
        run_until_pops(pop_cnt + 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
